// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - RAM write port bundle for adc_capture_ctrl
interface adc_capture_ctrl_if #(
   parameter int ADDR_W = 13
);
   logic              adc_we_o;
   logic [ADDR_W-1:0] adc_addr_o;
   logic [31:0]       adc_data_o;

   modport master (output adc_we_o, output adc_addr_o, output adc_data_o);
   modport slave  (input  adc_we_o, input  adc_addr_o, input  adc_data_o);
endinterface

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - ADC sample-set capture into RAM with decimation, trigger and ring mode
module adc_capture_ctrl #(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 12,
   parameter int ADDR_W   = 13
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [NUM_CH*SAMPLE_W-1:0] adc_sample_i,
   input  logic                       adc_valid_i,
   input  logic                       trig_i,
   input  logic                       csr_start_i,
   input  logic                       csr_stop_i,
   input  logic [ADDR_W-1:0]          csr_base_i,
   input  logic [ADDR_W-1:0]          csr_len_i,
   input  logic [7:0]                 csr_decim_i,
   input  logic                       csr_ring_i,
   input  logic                       csr_trig_en_i,
   output logic                       csr_busy_o,
   output logic                       csr_done_o,
   output logic                       csr_overrun_o,
   output logic                       csr_wrapped_o,
   output logic [ADDR_W-1:0]          csr_last_addr_o,
   adc_capture_ctrl_if.master         wr_if
);
   localparam int WPS   = (NUM_CH + 1) / 2;
   localparam int OFS_W = ADDR_W + 2;
   localparam bit TWO_W = (WPS == 2);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_e;
   state_e state_q, state_d;

   logic [ADDR_W-1:0]          base_q, len_q, addr_q, last_addr_q, wr_addr;
   logic [7:0]                 decim_q, dec_q;
   logic                       ring_q, stop_q, overrun_q, wrapped_q, we_q;
   logic [OFS_W-1:0]           offset_q, offset_inc, len_ext, limit, sched;
   logic [1:0]                 pend_q;
   logic [NUM_CH*SAMPLE_W-1:0] shadow_q;
   logic [31:0]                data_q;
   logic [3:0][15:0]           lane;
   logic [1:0][31:0]           word;
   logic                       in_cap, start_acc, stopping, writing, at_limit;
   logic                       can_take, take, overrun_hit, widx;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      if (k < NUM_CH) begin : g_ch
         assign lane[k] = 16'(shadow_q[k*SAMPLE_W +: SAMPLE_W]);
      end else begin : g_pad
         assign lane[k] = '0;
      end
   end
   assign word = lane;

   // Ring mode with zero length spans the whole address space in sets
   assign len_ext    = (len_q == '0 && ring_q) ? (OFS_W'(1) << ADDR_W) : OFS_W'(len_q);
   assign limit      = TWO_W ? {len_ext[OFS_W-2:0], 1'b0} : len_ext;
   assign in_cap     = (state_q == S_CAPTURE);
   assign start_acc  = csr_start_i && (state_q == S_IDLE || state_q == S_DONE);
   assign stopping   = stop_q || csr_stop_i;
   assign writing    = (pend_q != 2'd0);
   assign offset_inc = offset_q + OFS_W'(1);
   assign at_limit   = writing && (offset_inc == limit);
   assign sched      = offset_q + OFS_W'(pend_q);
   assign wr_addr    = base_q + offset_q[ADDR_W-1:0];
   assign widx       = TWO_W && (pend_q == 2'd1);

   // The last pending word leaves the shadow on this edge, so a new set may replace it
   assign can_take    = in_cap && adc_valid_i && (dec_q == 8'd0) && !stopping &&
                        (ring_q || sched < limit);
   assign take        = can_take && (pend_q <= 2'd1);
   assign overrun_hit = can_take && (pend_q > 2'd1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (csr_start_i) state_d = csr_trig_en_i ? S_ARM : S_CAPTURE;
         end
         S_ARM: begin
            if (csr_stop_i)  state_d = S_DONE;
            else if (trig_i) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (!ring_q && (limit == '0 || at_limit))  state_d = S_DONE;
            else if (stopping && pend_q <= 2'd1)       state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      csr_busy_o = 1'b0;
      csr_done_o = 1'b0;
      case (state_q)
         S_ARM, S_CAPTURE: csr_busy_o = 1'b1;
         S_DONE:           csr_done_o = 1'b1;
         default:          ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         base_q      <= '0;
         len_q       <= '0;
         decim_q     <= '0;
         ring_q      <= 1'b0;
         stop_q      <= 1'b0;
         dec_q       <= '0;
         offset_q    <= '0;
         pend_q      <= '0;
         shadow_q    <= '0;
         overrun_q   <= 1'b0;
         wrapped_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         last_addr_q <= '0;
      end else begin
         we_q <= 1'b0;
         if (start_acc) begin
            base_q    <= csr_base_i;
            len_q     <= csr_len_i;
            decim_q   <= csr_decim_i;
            ring_q    <= csr_ring_i;
            stop_q    <= 1'b0;
            dec_q     <= '0;
            offset_q  <= '0;
            overrun_q <= 1'b0;
            wrapped_q <= 1'b0;
         end else begin
            if (in_cap && csr_stop_i) stop_q <= 1'b1;
            if (in_cap && adc_valid_i) dec_q <= (dec_q == decim_q) ? 8'd0 : dec_q + 8'd1;
            if (overrun_hit) overrun_q <= 1'b1;
            if (writing) begin
               we_q        <= 1'b1;
               addr_q      <= wr_addr;
               last_addr_q <= wr_addr;
               data_q      <= word[widx];
               pend_q      <= pend_q - 2'd1;
               if (at_limit && ring_q) begin
                  offset_q  <= '0;
                  wrapped_q <= 1'b1;
               end else begin
                  offset_q  <= offset_inc;
               end
            end
            if (take) begin
               shadow_q <= adc_sample_i;
               pend_q   <= 2'(WPS);
            end
         end
      end
   end

   assign csr_overrun_o    = overrun_q;
   assign csr_wrapped_o    = wrapped_q;
   assign csr_last_addr_o  = last_addr_q;
   assign wr_if.adc_we_o   = we_q;
   assign wr_if.adc_addr_o = addr_q;
   assign wr_if.adc_data_o = data_q;
endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: ADC channels captured, legal range 1..4.
REQ-002 Parameter SAMPLE_W, default 12: bits per channel sample, legal range 1..16.
REQ-003 Parameter ADDR_W, default 13: word-address width of the RAM write port.
REQ-004 Derived WPS = ceil(NUM_CH/2): 32-bit words written per sample set.
REQ-005 sys_clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 adc_sample_i  in  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-008 adc_valid_i  in  1  sample-set strobe.
REQ-009 trig_i  in  1  external trigger, level-sampled.
REQ-010 csr_start_i / csr_stop_i  in  1 each  single-cycle command pulses.
REQ-011 csr_base_i  in  ADDR_W  first RAM word address.
REQ-012 csr_len_i  in  ADDR_W  capture length in sample sets.
REQ-013 csr_decim_i  in  8  keep one accepted set per (csr_decim_i+1) valid strobes.
REQ-014 csr_ring_i / csr_trig_en_i  in  1 each  ring mode; wait-for-trigger.
REQ-015 csr_busy_o, csr_done_o, csr_overrun_o, csr_wrapped_o  out  1 each  status.
REQ-016 csr_last_addr_o  out  ADDR_W  address of the most recent write.
REQ-017 adc_we_o  out  1; adc_addr_o  out  ADDR_W; adc_data_o  out  32: registered RAM write port.

Function
REQ-018 The module SHALL latch all csr_*_i configuration on an accepted start; later configuration changes SHALL have no effect until the next start.
REQ-019 The FSM SHALL have states IDLE, ARM, CAPTURE and DONE.
REQ-020 A start in IDLE or DONE SHALL go to ARM if csr_trig_en_i=1, otherwise to CAPTURE, and SHALL clear done, overrun, wrapped, and the decimation and offset counters.
REQ-021 A start in ARM or CAPTURE SHALL be ignored.
REQ-022 ARM SHALL go to CAPTURE on the first cycle after entry in which trig_i=1; trig_i in the start cycle SHALL be ignored.
REQ-023 In CAPTURE, the decimation counter SHALL count adc_valid_i strobes; a strobe is accepted when the counter equals 0, and the counter SHALL wrap at csr_decim_i.
REQ-024 An accepted set SHALL be latched into a shadow register.
REQ-025 Word w (0..WPS-1) of a set SHALL be {zero-extended ch(2w+1), zero-extended ch(2w)}, each occupying a 16-bit lane, with ch(2w) in bits [15:0].
REQ-026 An absent odd channel SHALL produce a zero upper lane.
REQ-027 Word w SHALL be written with adc_we_o=1 exactly w+1 cycles after the accepting edge, one word per cycle.
REQ-028 adc_addr_o SHALL equal (base + offset) mod 2^ADDR_W; offset SHALL increment by 1 per word written.
REQ-029 An adc_valid_i strobe arriving while shadow words remain unwritten SHALL be dropped, SHALL set csr_overrun_o (sticky), and SHALL still advance the decimation counter.
REQ-030 Single-shot mode: after offset reaches csr_len_i*WPS words, the FSM SHALL enter DONE; csr_done_o SHALL be 1 in DONE until the next start.
REQ-031 Ring mode: at csr_len_i*WPS words, offset SHALL wrap to 0 and csr_wrapped_o SHALL set (sticky); capture SHALL continue until stop.
REQ-032 A stop in ARM SHALL go directly to DONE with no writes.
REQ-033 A stop in CAPTURE SHALL finish the in-flight set and then enter DONE; no new set SHALL be accepted after the stop.
REQ-034 A stop in IDLE or DONE SHALL be ignored; if start and stop occur in the same cycle, start SHALL win and stop SHALL be ignored.
REQ-035 csr_len_i=0 SHALL make single-shot mode enter DONE with no writes once CAPTURE is reached, and SHALL make ring mode behave as a length of 2^ADDR_W sets.
REQ-036 csr_busy_o SHALL be 1 in ARM and CAPTURE.
REQ-037 csr_last_addr_o SHALL update on every write.

Reset
REQ-038 sys_rst=1 at any time, including mid-capture, SHALL on that edge force IDLE, adc_we_o=0, adc_addr_o=0, adc_data_o=0, all status outputs=0, csr_last_addr_o=0, and clear all counters and the shadow register.
REQ-039 An interrupted capture SHALL NOT resume after reset.

Verification
REQ-040 NUM_CH=2, base=0x400, len=4096, decim=0, valid every cycle with ch0 ramping from 0xAAA and ch1 from 0x555 -> RAM[0x400+i] = {4'h0,ch1_i,4'h0,ch0_i}, done=1, overrun=0.
REQ-041 NUM_CH=3, valid every cycle -> overrun=1 and alternate sets dropped; valid every 2nd cycle -> 2 words per set, upper lane of word 1 = 0, overrun=0.
REQ-042 decim=3, len=8 -> exactly sets 0,4,8,...,28 are written.
REQ-043 ring=1, base=0x1FFE, len=4, NUM_CH=2 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001,0x1FFE...; wrapped=1; stop -> DONE after the current set.
REQ-044 trig_en=1 with trig_i held 0 for 50 cycles -> no writes and busy=1; trig_i=1 -> capture starts; stop while in ARM -> DONE with zero writes.
REQ-045 sys_rst asserted mid-capture -> next cycle adc_we_o=0 and all outputs 0; a start after reset captures correctly from base.
